// File: rtl/spi_flash_master.sv
// SPI mode-0 master shifting one 32-bit word per start request, MSB first.
// Optional chaining of words inside one cs frame when SPI_MASTER_CONT_EN is defined.
module spi_flash_master (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [1:0]  freq,
  input  logic        en,
`ifdef SPI_MASTER_CONT_EN
  input  logic        cont,
`endif
  input  logic        miso,
  output logic [31:0] dout,
  output logic        transfer_succeded,
  output logic        busy,
  output logic        sck,
  output logic        cs,
  output logic        mosi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_TRAIL = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
`ifdef SPI_MASTER_CONT_EN
  localparam logic [2:0] S_HOLD  = 3'd4;
`endif

  logic [2:0]  state;
  logic [2:0]  div;
  logic [2:0]  half_m1;
  logic [4:0]  bit_cnt;
  logic        term;
  logic [31:0] tx;
  logic [31:0] rx;
  logic        start;
  logic        chain;

  function automatic logic [2:0] half_load(input logic [1:0] f);
    case (f)
      2'd0:    half_load = 3'd0;
      2'd1:    half_load = 3'd1;
      2'd2:    half_load = 3'd3;
      default: half_load = 3'd7;
    endcase
  endfunction

  assign start = en && !busy;
  assign term  = &bit_cnt;

`ifdef SPI_MASTER_CONT_EN
  logic cont_q;
  always_ff @(posedge clk) begin
    if (!rst)
      cont_q <= 1'b0;
    else if (start)
      cont_q <= cont;
  end
  assign chain = cont_q;
`else
  assign chain = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      cs                <= 1'b1;
      sck               <= 1'b0;
      mosi              <= 1'b0;
      busy              <= 1'b0;
      transfer_succeded <= 1'b0;
      dout              <= 32'd0;
      div               <= 3'd0;
      bit_cnt           <= 5'd0;
    end else begin
      transfer_succeded <= 1'b0;
      case (state)
`ifdef SPI_MASTER_CONT_EN
        S_IDLE, S_HOLD: begin
`else
        S_IDLE: begin
`endif
          if (start) begin
            tx      <= din;
            mosi    <= din[31];
            half_m1 <= half_load(freq);
            div     <= half_load(freq);
            bit_cnt <= 5'd0;
            cs      <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div != 3'd0) begin
            div <= div - 3'd1;
          end else begin
            div <= half_m1;
            sck <= ~sck;
            if (!sck) begin
              rx <= {rx[30:0], miso};
            end else begin
              tx   <= {tx[30:0], 1'b0};
              mosi <= tx[30];
              if (term) begin
                state <= S_TRAIL;
                // chained words skip the trailing half period
                if (chain)
                  div <= 3'd0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
        end
        S_TRAIL: begin
          if (div != 3'd0) begin
            div <= div - 3'd1;
          end else begin
            dout              <= rx;
            transfer_succeded <= 1'b1;
            div               <= half_m1;
`ifdef SPI_MASTER_CONT_EN
            if (chain) begin
              busy  <= 1'b0;
              state <= S_HOLD;
            end else begin
              cs    <= 1'b1;
              state <= S_GAP;
            end
`else
            cs    <= 1'b1;
            state <= S_GAP;
`endif
          end
        end
        S_GAP: begin
          if (div != 3'd0) begin
            div <= div - 3'd1;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Randomised bench for spi_flash_master against a cycle-timing model derived from the transfer rules.
// Define SPI_MASTER_CONT_EN to also exercise chained words.
module tb_spi_flash_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [1:0]  freq;
  logic        en;
  logic        cont;
  logic        miso;
  logic [31:0] dout;
  logic        ts;
  logic        busy;
  logic        sck;
  logic        cs;
  logic        mosi;

  spi_flash_master dut (
    .clk(clk), .rst(rst), .din(din), .freq(freq), .en(en),
`ifdef SPI_MASTER_CONT_EN
    .cont(cont),
`endif
    .miso(miso), .dout(dout), .transfer_succeded(ts), .busy(busy),
    .sck(sck), .cs(cs), .mosi(mosi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  localparam int BOUND = 1200;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: position t cycles after the accepting edge decides every output
  bit          m_act = 0, m_hold = 0, m_cont = 0;
  int          m_t = 0, m_h = 1;
  logic [31:0] m_din = 0, m_rx = 0, e_dout = 0;
  logic        e_cs = 1, e_sck = 0, e_busy = 0, e_ts = 0, e_mosi = 0, e_mchk = 0;

  always @(posedge clk) begin
    e_ts = 0;
    if (!rst) begin
      m_act = 0; m_hold = 0; e_dout = 0;
    end else if (m_act) begin
      m_t++;
      if (m_t < 64 * m_h && (m_t % (2 * m_h)) == m_h)
        m_rx = {m_rx[30:0], miso};
      if (m_cont && m_t == 64 * m_h + 1) begin
        e_dout = m_rx; e_ts = 1; m_act = 0; m_hold = 1;
      end else if (!m_cont && m_t == 65 * m_h) begin
        e_dout = m_rx; e_ts = 1;
      end else if (!m_cont && m_t == 66 * m_h) begin
        m_act = 0;
      end
    end else if (en) begin
      m_act = 1; m_hold = 0; m_t = 0; m_h = 1 << freq; m_din = din;
`ifdef SPI_MASTER_CONT_EN
      m_cont = cont;
`else
      m_cont = 0;
`endif
    end
    e_mchk = 0;
    if (m_act) begin
      e_busy = 1;
      if (m_t < 64 * m_h) begin
        e_cs = 0; e_sck = ((m_t / m_h) % 2) == 1;
        e_mchk = 1; e_mosi = m_din[31 - m_t / (2 * m_h)];
      end else begin
        e_sck = 0; e_cs = (m_t >= 65 * m_h);
      end
    end else begin
      e_busy = 0; e_sck = 0; e_cs = !m_hold;
    end
  end

  bit chk_on = 0;
  bit p_sck = 0, p_cs = 1;
  int n_rise = 0, n_ts = 0, n_csr = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cs", 32'(cs), 32'(e_cs));
      chk("sck", 32'(sck), 32'(e_sck));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("transfer_succeded", 32'(ts), 32'(e_ts));
      chk("dout", dout, e_dout);
      if (e_mchk) chk("mosi", 32'(mosi), 32'(e_mosi));
      if (!p_sck && sck) n_rise++;
      if (ts) n_ts++;
      if (!p_cs && cs) n_csr++;
      p_sck = sck; p_cs = cs;
    end
  end

  // Slave: 0 loops mosi back, 1 shifts out pat on sck falls, 2 random bits
  int          mode = 0;
  logic [31:0] pat = 0;
  int          sidx = 0;
  bit          s_cs = 1, s_sck = 0;

  always @(negedge clk) begin
    if (s_cs && !cs) sidx = 0;
    else if (s_sck && !sck) sidx++;
    s_cs = cs; s_sck = sck;
    case (mode)
      0:       miso = mosi;
      1:       miso = (sidx < 32) ? pat[31 - sidx] : 1'b0;
      default: miso = 1'($urandom);
    endcase
  end

  task automatic run_xfer(input logic [31:0] d, input logic [1:0] f, input logic c,
                          output int lat_ts, output int lat_idle);
    int n;
    @(negedge clk); din = d; freq = f; cont = c; en = 1;
    @(negedge clk); en = 0;
    lat_ts = -1; n = 0;
    while (busy && n < BOUND) begin
      @(negedge clk); n++;
      if (ts && lat_ts < 0) lat_ts = n;
    end
    lat_idle = n;
    chk("xfer_done_in_bound", 32'(n < BOUND), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < BOUND) begin @(negedge clk); n++; end
    chk("idle_in_bound", 32'(n < BOUND), 32'd1);
  endtask

  initial begin
    int lt, li, ts0;
    logic [31:0] d1, d2;
    rst = 0; en = 0; din = 0; freq = 0; cont = 0; miso = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    rst = 1;

    mode = 0;
    run_xfer(32'h0312_3456, 2'b00, 1'b0, lt, li);
    chk("loop_ts_latency", lt, 65);
    chk("loop_idle_latency", li, 66);
    chk("loop_dout", dout, 32'h0312_3456);

    @(negedge clk); din = 32'hDEAD_BEEF; freq = 2'b01; en = 1;
    @(negedge clk); en = 0;
    repeat (40) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_cs", 32'(cs), 32'd1);
    chk("rst_mid_sck", 32'(sck), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dout", dout, 32'd0);
    chk("rst_mid_mosi", 32'(mosi), 32'd0);
    rst = 1;

    mode = 1; pat = 32'hA5A5_5A5A;
    run_xfer(32'h1234_5678, 2'b11, 1'b0, lt, li);
    chk("slow_ts_latency", lt, 520);
    chk("slow_idle_latency", li, 528);
    chk("slow_dout", dout, 32'hA5A5_5A5A);

    mode = 0; d1 = 32'hC33C_0FF0; d2 = 32'h5A01_FE80;
    ts0 = n_ts;
    @(negedge clk); din = d1; freq = 2'b00; en = 1;
    repeat (20) @(negedge clk);
    din = d2; freq = 2'b10;
    wait_idle();
    chk("held_first_dout", dout, d1);
    @(negedge clk); en = 0;
    wait_idle();
    chk("held_second_dout", dout, d2);
    chk("held_ts_count", n_ts - ts0, 2);

    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 2);
      pat = $urandom;
      d1 = $urandom;
      run_xfer(d1, 2'($urandom_range(0, 2)), 1'b0, lt, li);
      if (mode == 0) chk("rand_loop_dout", dout, d1);
      if (mode == 1) chk("rand_pat_dout", dout, pat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef SPI_MASTER_CONT_EN
    mode = 0;
    n_rise = 0; ts0 = n_ts; n_csr = 0;
    run_xfer(32'h0300_0100, 2'b00, 1'b1, lt, li);
    chk("chain_first_ts_latency", lt, 65);
    chk("chain_first_dout", dout, 32'h0300_0100);
    chk("chain_cs_held", 32'(cs), 32'd0);
    repeat (2) @(negedge clk);
    run_xfer(32'h0000_0000, 2'b00, 1'b0, lt, li);
    chk("chain_second_idle", li, 66);
    chk("chain_sck_pulses", n_rise, 64);
    chk("chain_ts_count", n_ts - ts0, 2);
    chk("chain_cs_rises", n_csr, 1);
    chk("chain_second_dout", dout, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
